game_flow_ctrl: RTL and testbench
=================================

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter WIN_Y, default 16000, meaning: y_ball threshold; y_ball > WIN_Y is a win.
REQ-002 Parameter FRAMES_PER_STEP, default 3, meaning: frames per jump-animation step (1..15).
REQ-003 Parameter FALL_FRAMES, default 30, meaning: frames the fall animation shows before gameover (1..63).
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 clrn  input  1  reset, asynchronous, active-low.
REQ-006 vs  input  1  VGA vertical sync from the VGA driver, active-low, asynchronous to clk.
REQ-007 start  input  1  level request to start or restart a game.
REQ-008 jump  input  1  level jump request from the player.
REQ-009 fail  input  1  ball-over-hole indication from the physics block.
REQ-010 y_ball  input  26  ball forward position.
REQ-011 ball_state  output  3  sprite size select, 0=62 px through 5=92 px.
REQ-012 run  output  1  enables physics and scrolling; high only in PLAY.
REQ-013 gameover  output  1  selects the gameover screen.
REQ-014 victory  output  1  selects the victory screen.
REQ-015 frame_tick  output  1  one-clk pulse per frame.

Function
REQ-016 vs SHALL pass through a 2-flop synchroniser, and frame_tick SHALL pulse for exactly one clk on each synchronised falling edge.
REQ-017 start and jump SHALL be rising-edge detected in clk; a held level SHALL generate one event only.
REQ-018 FSM states SHALL be IDLE, PLAY, FALL, OVER and WIN.
- IDLE: run=0, ball_state=1; a start edge moves to PLAY.
- PLAY: run=1; fail moves to FALL; y_ball > WIN_Y moves to WIN.
- FALL: run=0; fall animation plays, then the FSM moves to OVER.
- OVER: gameover=1, run=0; a start edge moves to IDLE.
- WIN: victory=1, run=0; a start edge moves to IDLE.
REQ-019 If win and fail are both true in PLAY in the same cycle, the FSM SHALL go to WIN.
REQ-020 Comparisons SHALL be unsigned 26-bit; y_ball == WIN_Y SHALL NOT be a win.
REQ-021 Jump animation SHALL run in PLAY only, and a jump edge SHALL start it only when the animation is idle.
- Sequence: 1,2,3,4,5,5,4,3,2,1.
- Each entry is held FRAMES_PER_STEP frame_ticks.
- The first entry (1) is presented from the cycle after the edge.
- Jump edges during an animation SHALL be ignored.
REQ-022 In PLAY with no animation active, ball_state SHALL be 1.
REQ-023 While the jump animation is active, fail SHALL be masked.
REQ-024 On FALL entry, ball_state SHALL go 1 then 0, changing at the next frame_tick, and then hold 0.
REQ-025 FALL SHALL last FALL_FRAMES frame_ticks, counted from entry, before the FSM moves to OVER.
REQ-026 In OVER and WIN, ball_state SHALL hold its last value.
REQ-027 gameover and victory SHALL be registered outputs, mutually exclusive, and change in the cycle after the state transition.
REQ-028 Frame and step counters SHALL clear on every state entry; counters SHALL NOT wrap, saturating at their terminal count.
REQ-029 A start edge in PLAY or FALL SHALL be ignored.

Reset
REQ-030 On clrn low, asynchronously:
- state = IDLE;
- ball_state = 1;
- run, gameover, victory, frame_tick = 0;
- synchroniser and edge-detect flops = 1 for vs and 0 for start and jump;
- all counters = 0.
REQ-031 Reset mid-animation or mid-FALL SHALL abort it; no event SHALL be generated on reset release, even with start held high.

Structure
REQ-032 The state encoding, the jump-sequence table and the ball_state size codes SHALL live in a shared package, game_pkg, which the display path also uses.
REQ-033 The vs synchroniser and edge detector SHALL be one sub-module, frame_sync.

Verification
REQ-034 Start and jump: reset, pulse start, then jump, with FRAMES_PER_STEP=1 -> run=1; ball_state is 1,2,3,4,5,5,4,3,2,1 on successive frames, then holds 1.
REQ-035 Fail in PLAY, no jump -> ball_state goes 1 then 0 at the next tick; run=0; gameover=1 exactly 30 ticks after FALL entry.
REQ-036 Win boundary: y_ball=16000 -> stays in PLAY; y_ball=16001 -> victory=1 the next cycle. Win and fail in the same cycle -> victory=1, gameover=0.
REQ-037 Masking: a jump edge mid-animation -> no restart; fail during the animation -> ignored; fail held after the animation -> FALL.
REQ-038 Reset and restart: clrn low during FALL -> all outputs at reset values immediately; start held through reset release -> stays in IDLE; in OVER, a start edge -> IDLE, then another edge -> PLAY.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: FSM states, ball sprite size codes and the jump-animation table.
// The display path imports this package as well.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_FALL,
        ST_OVER,
        ST_WIN
    } game_state_e;

    // Sprite size codes; the display maps these to 62..92 px in 6 px steps
    localparam logic [2:0] BS_62 = 3'd0;
    localparam logic [2:0] BS_68 = 3'd1;
    localparam logic [2:0] BS_74 = 3'd2;
    localparam logic [2:0] BS_80 = 3'd3;
    localparam logic [2:0] BS_86 = 3'd4;
    localparam logic [2:0] BS_92 = 3'd5;

    localparam int JUMP_LEN = 10;

    // Jump arc: grow to the largest sprite and shrink back symmetrically
    function automatic logic [2:0] jump_code(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd9: jump_code = BS_68;
            4'd1, 4'd8: jump_code = BS_74;
            4'd2, 4'd7: jump_code = BS_80;
            4'd3, 4'd6: jump_code = BS_86;
            4'd4, 4'd5: jump_code = BS_92;
            default:    jump_code = BS_68;
        endcase
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Player/physics/VGA signals seen by the game flow controller.
interface game_flow_ctrl_if;
    logic        vs;
    logic        start;
    logic        jump;
    logic        fail;
    logic [25:0] y_ball;
    logic [2:0]  ball_state;
    logic        run;
    logic        gameover;
    logic        victory;
    logic        frame_tick;

    modport master (
        output vs, start, jump, fail, y_ball,
        input  ball_state, run, gameover, victory, frame_tick
    );

    modport slave (
        input  vs, start, jump, fail, y_ball,
        output ball_state, run, gameover, victory, frame_tick
    );
endinterface

// File: rtl/game_flow_ctrl_frame_sync.sv
// Brings the asynchronous active-low VGA vsync into clk and emits one tick per frame.
module frame_sync (
    input  logic clk,
    input  logic clrn,
    input  logic vs,
    output logic frame_tick
);
    logic vs_s1, vs_s2, vs_d;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            vs_s1      <= 1'b1;
            vs_s2      <= 1'b1;
            vs_d       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vs_s1      <= vs;
            vs_s2      <= vs_s1;
            vs_d       <= vs_s2;
            frame_tick <= vs_d & ~vs_s2;
        end
    end
endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow FSM: start/play/fall/over/win sequencing, jump animation and sprite size select.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned WIN_Y           = 16000,
    parameter int unsigned FRAMES_PER_STEP = 3,
    parameter int unsigned FALL_FRAMES     = 30
) (
    input  logic             clk,
    input  logic             clrn,
    game_flow_ctrl_if.slave  bus
);
    localparam logic [25:0] WIN_THR   = 26'(WIN_Y);
    localparam logic [5:0]  STEP_LAST = 6'(FRAMES_PER_STEP - 1);
    localparam logic [5:0]  FALL_LAST = 6'(FALL_FRAMES - 1);
    localparam logic [3:0]  JUMP_LAST = 4'(JUMP_LEN - 1);

    game_state_e state, state_next;
    logic        frame_tick;
    logic        start_q, jump_q, armed;
    logic        start_edge, jump_edge;
    logic        anim_active;
    logic [3:0]  step;
    logic [5:0]  fcnt;
    logic [2:0]  ball_state;
    logic        gameover, victory;
    logic        win, fail_eff;

    frame_sync u_frame_sync (
        .clk        (clk),
        .clrn       (clrn),
        .vs         (bus.vs),
        .frame_tick (frame_tick)
    );

    // armed stays low for the first clock after reset so a held level is not seen as an edge
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            start_q <= 1'b0;
            jump_q  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            start_q <= bus.start;
            jump_q  <= bus.jump;
            armed   <= 1'b1;
        end
    end

    assign start_edge = armed & bus.start & ~start_q;
    assign jump_edge  = armed & bus.jump & ~jump_q;
    assign win        = bus.y_ball > WIN_THR;
    assign fail_eff   = bus.fail & ~anim_active;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:         if (start_edge) state_next = ST_PLAY;
            ST_PLAY: begin
                if (win)           state_next = ST_WIN;
                else if (fail_eff) state_next = ST_FALL;
            end
            ST_FALL:         if (frame_tick && fcnt == FALL_LAST) state_next = ST_OVER;
            ST_OVER, ST_WIN: if (start_edge) state_next = ST_IDLE;
            default:         state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            anim_active <= 1'b0;
            step        <= '0;
            fcnt        <= '0;
            ball_state  <= BS_68;
        end else if (state_next != state) begin
            anim_active <= 1'b0;
            step        <= '0;
            fcnt        <= '0;
            if (state_next inside {ST_IDLE, ST_PLAY, ST_FALL}) ball_state <= BS_68;
        end else begin
            case (state)
                ST_IDLE: ball_state <= BS_68;
                ST_PLAY: begin
                    if (!anim_active) begin
                        ball_state <= BS_68;
                        if (jump_edge) begin
                            anim_active <= 1'b1;
                            ball_state  <= jump_code(4'd0);
                        end
                    end else if (frame_tick) begin
                        if (fcnt == STEP_LAST) begin
                            fcnt <= '0;
                            if (step == JUMP_LAST) begin
                                anim_active <= 1'b0;
                                step        <= '0;
                                ball_state  <= BS_68;
                            end else begin
                                step       <= step + 4'd1;
                                ball_state <= jump_code(step + 4'd1);
                            end
                        end else begin
                            fcnt <= fcnt + 6'd1;
                        end
                    end
                end
                ST_FALL: begin
                    if (frame_tick) begin
                        ball_state <= BS_62;
                        if (fcnt != FALL_LAST) fcnt <= fcnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            gameover <= 1'b0;
            victory  <= 1'b0;
        end else begin
            gameover <= (state == ST_OVER);
            victory  <= (state == ST_WIN);
        end
    end

    assign bus.run        = (state == ST_PLAY);
    assign bus.ball_state = ball_state;
    assign bus.gameover   = gameover;
    assign bus.victory    = victory;
    assign bus.frame_tick = frame_tick;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with FRAMES_PER_STEP=1 and default WIN_Y/FALL_FRAMES.
module tb_game_flow_ctrl;
    logic clk;
    logic clrn;
    int   checks;
    int   errors;
    int   tick_seen;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(.WIN_Y(16000), .FRAMES_PER_STEP(1), .FALL_FRAMES(30)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One vsync frame: 4 clocks low then 4 high; the tick is fully consumed by the end
    task automatic frame();
        bus.vs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.frame_tick) tick_seen++;
        end
        bus.vs = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.frame_tick) tick_seen++;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_jump();
        bus.jump = 1'b1;
        @(negedge clk);
        bus.jump = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        cycles(2);
        checks++;
        if (bus.ball_state !== 3'd1) begin
            errors++;
            $display("FAIL reset_ball_state: got %0d expected 1", bus.ball_state);
        end
        check_bit("reset_run", bus.run, 1'b0);
        check_bit("reset_gameover", bus.gameover, 1'b0);
        check_bit("reset_victory", bus.victory, 1'b0);
        check_bit("reset_frame_tick", bus.frame_tick, 1'b0);
        clrn = 1'b1;
        cycles(2);
    endtask

    task automatic test_frame_tick();
        tick_seen = 0;
        frame();
        checks++;
        if (tick_seen !== 1) begin
            errors++;
            $display("FAIL frame_tick_count: got %0d expected 1", tick_seen);
        end
        check_bit("idle_run", bus.run, 1'b0);
    endtask

    task automatic test_start_jump();
        int seq [10] = '{1, 2, 3, 4, 5, 5, 4, 3, 2, 1};
        pulse_start();
        check_bit("start_run", bus.run, 1'b1);
        pulse_jump();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) frame();
            checks++;
            if (bus.ball_state !== 3'(seq[k])) begin
                errors++;
                $display("FAIL jump_seq[%0d]: got %0d expected %0d", k, bus.ball_state, seq[k]);
            end
        end
        frame();
        checks++;
        if (bus.ball_state !== 3'd1) begin
            errors++;
            $display("FAIL jump_end: got %0d expected 1", bus.ball_state);
        end
        frame();
        checks++;
        if (bus.ball_state !== 3'd1) begin
            errors++;
            $display("FAIL jump_hold: got %0d expected 1", bus.ball_state);
        end
    endtask

    task automatic test_mask();
        pulse_jump();
        frame(); frame(); frame();
        pulse_jump();
        frame();
        checks++;
        if (bus.ball_state !== 3'd5) begin
            errors++;
            $display("FAIL jump_no_restart: got %0d expected 5", bus.ball_state);
        end
        bus.fail = 1'b1;
        for (int k = 5; k < 10; k++) frame();
        check_bit("fail_masked_run", bus.run, 1'b1);
        frame();
        check_bit("fail_after_anim_run", bus.run, 1'b0);
        bus.fail = 1'b0;
        checks++;
        if (bus.ball_state !== 3'd1) begin
            errors++;
            $display("FAIL fall_entry_ball: got %0d expected 1", bus.ball_state);
        end
    endtask

    task automatic test_reset_mid();
        frame(); frame(); frame();
        checks++;
        if (bus.ball_state !== 3'd0) begin
            errors++;
            $display("FAIL fall_ball_zero: got %0d expected 0", bus.ball_state);
        end
        bus.start = 1'b1;
        clrn = 1'b0;
        #1;
        checks++;
        if (bus.ball_state !== 3'd1) begin
            errors++;
            $display("FAIL midreset_ball: got %0d expected 1", bus.ball_state);
        end
        check_bit("midreset_run", bus.run, 1'b0);
        check_bit("midreset_gameover", bus.gameover, 1'b0);
        cycles(2);
        clrn = 1'b1;
        cycles(4);
        check_bit("release_start_held_run", bus.run, 1'b0);
        bus.start = 1'b0;
        cycles(1);
        pulse_start();
        check_bit("restart_after_reset_run", bus.run, 1'b1);
    endtask

    task automatic test_fall();
        bus.fail = 1'b1;
        @(negedge clk);
        bus.fail = 1'b0;
        check_bit("fall_run", bus.run, 1'b0);
        checks++;
        if (bus.ball_state !== 3'd1) begin
            errors++;
            $display("FAIL fall_first_ball: got %0d expected 1", bus.ball_state);
        end
        frame();
        checks++;
        if (bus.ball_state !== 3'd0) begin
            errors++;
            $display("FAIL fall_second_ball: got %0d expected 0", bus.ball_state);
        end
        for (int k = 2; k < 30; k++) frame();
        check_bit("fall_29_gameover", bus.gameover, 1'b0);
        frame();
        check_bit("fall_30_gameover", bus.gameover, 1'b1);
        check_bit("over_victory", bus.victory, 1'b0);
        checks++;
        if (bus.ball_state !== 3'd0) begin
            errors++;
            $display("FAIL over_ball_hold: got %0d expected 0", bus.ball_state);
        end
    endtask

    task automatic test_restart();
        pulse_start();
        check_bit("over_to_idle_gameover", bus.gameover, 1'b0);
        check_bit("over_to_idle_run", bus.run, 1'b0);
        checks++;
        if (bus.ball_state !== 3'd1) begin
            errors++;
            $display("FAIL idle_ball: got %0d expected 1", bus.ball_state);
        end
        pulse_start();
        check_bit("idle_to_play_run", bus.run, 1'b1);
    endtask

    task automatic test_win();
        bus.y_ball = 26'd16000;
        cycles(3);
        check_bit("win_eq_run", bus.run, 1'b1);
        check_bit("win_eq_victory", bus.victory, 1'b0);
        bus.y_ball = 26'd16001;
        cycles(2);
        check_bit("win_victory", bus.victory, 1'b1);
        check_bit("win_run", bus.run, 1'b0);
        bus.y_ball = 26'd0;
        pulse_start();
        pulse_start();
        check_bit("replay_run", bus.run, 1'b1);
        bus.y_ball = 26'd16001;
        bus.fail   = 1'b1;
        cycles(2);
        bus.fail   = 1'b0;
        check_bit("winfail_victory", bus.victory, 1'b1);
        check_bit("winfail_gameover", bus.gameover, 1'b0);
        bus.y_ball = 26'd0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        tick_seen = 0;
        clrn       = 1'b0;
        bus.vs     = 1'b1;
        bus.start  = 1'b0;
        bus.jump   = 1'b0;
        bus.fail   = 1'b0;
        bus.y_ball = 26'd0;
        test_reset();
        test_frame_tick();
        test_start_jump();
        test_mask();
        test_reset_mid();
        test_fall();
        test_restart();
        test_win();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
